uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with a buffered output. Successor to the fixed
//  serial_rx path in main.
//  - Oversamples serial_rx at the system clock and decodes 8N1-style frames.
//  - Configurable data width and baud divisor.
//  - Pushes received words into a first-word-fall-through (FWFT) FIFO,
//    drained via a valid/ready handshake.
//  - Reports framing and overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); legal range >= 4
//  DATA_BITS     8    data bits per frame, LSB first; legal range 5..9
//  FIFO_DEPTH    16   receive FIFO entries; power of 2, >= 2
//  PARITY_ODD    0    1 = odd parity, 0 = even; only used with UART_PARITY_EN
// PORTS
//  clk          in   1                        system clock, rising edge
//  rst          in   1                        asynchronous reset, active-high
//  serial_rx    in   1                        UART line, idles high, asynchronous to clk
//  rx_data      out  DATA_BITS                FIFO head word, valid when rx_valid=1
//  rx_valid     out  1                        FIFO not empty
//  rx_ready     in   1                        consumer accepts; pop when rx_valid & rx_ready
//  fifo_count   out  $clog2(FIFO_DEPTH)+1     current FIFO occupancy
//  frame_err    out  1                        1-cycle pulse: stop bit sampled low
//  overrun_err  out  1                        1-cycle pulse: word dropped, FIFO full
//  parity_err   out  1                        1-cycle pulse (UART_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset values
//  - Asserting rst aborts any frame in progress.
//  - FSM=IDLE; FIFO empty; rx_valid=0, rx_data=0, fifo_count=0; all *_err=0.
//  - The 2-FF synchroniser on serial_rx resets to 1 (idle line).
//  FSM, on synchronised rx_s; bit counter cnt, bit index idx
//  - IDLE:  rx_s==0 -> START, cnt=0.
//  - START: at cnt==CLKS_PER_BIT/2-1, sample rx_s. 0 -> DATA, cnt=0, idx=0.
//           1 -> IDLE (glitch rejected, nothing pushed).
//  - DATA:  at cnt==CLKS_PER_BIT-1 (mid-bit), shift rx_s into bit idx, LSB first.
//           After bit DATA_BITS-1 -> PARITY if enabled, else STOP.
//  - PARITY: sample one bit at mid-bit -> STOP.
//  - STOP:  sample at mid-bit.
//           1 -> push word, -> IDLE.
//           0 -> frame_err pulse, word discarded, -> BREAK.
//  - BREAK: wait for rx_s==1 -> IDLE. A held-low line yields exactly one frame_err.
//  Latency
//  - rx_valid rises 1 clk after the stop-bit sample clock, when the FIFO was empty.
//  - Input path adds 2 clks of synchroniser delay.
//  FIFO
//  - FWFT: rx_data shows the head word whenever rx_valid=1.
//  - Push on a full FIFO without a pop in the same cycle: word dropped,
//    overrun_err pulse, contents unchanged.
//  - Push and pop in the same cycle, including when full: both take effect,
//    fifo_count unchanged, no overrun.
//  - Pop when empty is ignored.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_count distinguishes full from empty.
//  Concurrency
//  - Error pulses may coincide with FIFO pops; they are independent.
// CONFIGURATION
//  UART_PARITY_EN defined
//  - FSM inserts the PARITY state after the data bits.
//  - Expected parity bit = ^data ^ PARITY_ODD.
//  - On mismatch: parity_err pulses at the stop-bit sample clock; the word is
//    discarded; the stop bit is still checked.
//  UART_PARITY_EN undefined
//  - No PARITY state; parity_err is tied 0; PARITY_ODD is ignored.
// TESTING  (bench: CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
//  1. Send frame 0x49, rx_ready=0 -> rx_valid=1, rx_data=0x49, fifo_count=1, no errors.
//  2. Send 0x00 then 0xFF back-to-back, then rx_ready=1 -> pops 0x00 then 0xFF;
//     rx_valid=0 after 2 pops.
//  3. Send 5 frames 0x01..0x05, rx_ready=0 -> fifo_count=4, one overrun_err on
//     frame 5, head=0x01.
//  4. Frame 0x55 with stop bit=0, line held low 40 clks -> exactly one frame_err,
//     fifo_count unchanged.
//  5. 1-clk low glitch on serial_rx; rst pulse mid-frame -> nothing pushed; after
//     rst all outputs are 0; next frame 0xA5 decodes correctly.
//  6. UART_PARITY_EN, PARITY_ODD=0: 0x03 with parity bit 1 -> parity_err pulse,
//     no push; 0x03 with parity bit 0 -> pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through FIFO.
// Parity checking is compiled in by defining UART_PARITY_EN.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        serial_rx,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic                        parity_err
);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | timing to mid start bit, re-checking it is still low
  // S_DATA   | sampling data bits at mid-bit, LSB first
  // S_PARITY | sampling the parity bit (parity builds only)
  // S_STOP   | sampling the stop bit, push or flag error
  // S_BREAK  | stop bit was low, waiting for the line to return high

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state, next_state;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tc, last_bit, push, par_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rx_s    <= rx_meta;
    end
  end

  // Down-counter: terminal count marks the sample clock of the current bit.
  assign tc       = (cnt == '0);
  assign last_bit = (idx == IDX_W'(DATA_BITS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (!rx_s) next_state = S_START;
      S_START:  if (tc) next_state = rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (tc && last_bit) begin
`ifdef UART_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
      S_PARITY: if (tc) next_state = S_STOP;
      S_STOP:   if (tc) next_state = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    if (state == S_STOP && tc) begin
      push       = rx_s && !par_bad;
      frame_err  = !rx_s;
      parity_err = par_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= CNT_W'(HALF-1);
          idx <= '0;
        end
        S_BREAK: cnt <= CNT_W'(HALF-1);
        default: cnt <= tc ? CNT_W'(CLKS_PER_BIT-1) : cnt - 1'b1;
      endcase
      if (state == S_DATA && tc) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        idx   <= idx + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         par_bit <= 1'b0;
    else if (state == S_PARITY && tc) par_bit <= rx_s;
  end

  assign par_bad = par_bit != (^shreg ^ PARITY_ODD);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_bad           = 1'b0;
`endif

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign rx_valid    = (fifo_count != '0);
  assign full        = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop         = rx_valid && rx_ready;
  assign wr_en       = push && (!full || pop);
  assign overrun_err = push && full && !pop;
  assign rx_data     = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a frame-level queue model.
module tb_uart_rx_fifo;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam bit PODD  = 1'b0;
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_rx;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [2:0]    fifo_count;
  logic          frame_err, overrun_err, parity_err;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int fe_exp = 0, ov_exp = 0, pe_exp = 0;
  logic [DW-1:0] exp_q[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .rst(rst), .serial_rx(serial_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .frame_err(frame_err),
    .overrun_err(overrun_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (frame_err === 1'b1)   fe_cnt++;
      if (overrun_err === 1'b1) ov_cnt++;
      if (parity_err === 1'b1)  pe_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_rx = b;
    idle(CPB);
  endtask

  // Sends one frame and applies the frame rules to the reference model.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic bad_par);
    logic par_ok;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(^d ^ PODD ^ bad_par);
    drive_bit(stop);
    par_ok = !(PAR_EN && bad_par);
    if (!stop)   fe_exp++;
    if (!par_ok) pe_exp++;
    if (stop && par_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      ov_exp++;
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, ".count"}, 32'(fifo_count), 32'(exp_q.size()));
    check({tag, ".valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, ".head"}, 32'(rx_data), 32'(exp_q[0]));
    check({tag, ".frame_err"},   fe_cnt, fe_exp);
    check({tag, ".overrun_err"}, ov_cnt, ov_exp);
    check({tag, ".parity_err"},  pe_cnt, pe_exp);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check({tag, ".pop_valid"}, 32'(rx_valid), 32'(1));
      check({tag, ".pop_data"},  32'(rx_data),  32'(exp_q[0]));
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check({tag, ".empty_valid"}, 32'(rx_valid),   32'(0));
    check({tag, ".empty_count"}, 32'(fifo_count), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, ".valid"},   32'(rx_valid),    32'(0));
    check({tag, ".data"},    32'(rx_data),     32'(0));
    check({tag, ".count"},   32'(fifo_count),  32'(0));
    check({tag, ".fe"},      32'(frame_err),   32'(0));
    check({tag, ".ov"},      32'(overrun_err), 32'(0));
    check({tag, ".pe"},      32'(parity_err),  32'(0));
  endtask

  int            nf;
  logic [DW-1:0] rd;
  logic          rstop, rbp;

  initial begin
    rst       = 1'b1;
    serial_rx = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    idle(1);
    rst = 1'b0;
    idle(5);

    send_frame(8'h49, 1'b1, 1'b0);
    idle(CPB);
    check_status("t1");
    drain("t1");

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(CPB);
    check_status("t2");
    drain("t2");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(CPB);
    check_status("t3");

    send_frame(8'h55, 1'b0, 1'b0);
    idle(40);
    serial_rx = 1'b1;
    idle(8);
    check_status("t4");
    drain("t4");

    serial_rx = 1'b0;
    idle(1);
    serial_rx = 1'b1;
    idle(20);
    check_status("t5_glitch");

    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rst       = 1'b1;
    serial_rx = 1'b1;
    idle(2);
    check_reset_outputs("t5_rst");
    idle(1);
    rst = 1'b0;
    idle(10);
    check_reset_outputs("t5_after");
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(CPB);
    check_status("t5_a5");
    drain("t5");

`ifdef UART_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(CPB);
    check_status("t6_bad");
    send_frame(8'h03, 1'b1, 1'b0);
    idle(CPB);
    check_status("t6_good");
    drain("t6");
`endif

    for (int r = 0; r < 25; r++) begin
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        rd    = 8'($urandom);
        rstop = ($urandom_range(0, 7) != 0);
        rbp   = PAR_EN && ($urandom_range(0, 5) == 0);
        send_frame(rd, rstop, rbp);
        if (!rstop) begin
          idle($urandom_range(1, 20));
          serial_rx = 1'b1;
          idle(CPB);
        end
        idle($urandom_range(0, 4));
      end
      idle(CPB);
      check_status("rand");
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
